// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with saturating match counter
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W = $clog2(MAX_LEN + 1),
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               dataIn,
    input  logic               cfgLoad,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   patLen,
    input  logic               overlap,
    input  logic               clrCount,
    output logic               detected,
    output logic [CNT_W-1:0]   matchCount,
    output logic               cfgErr,
    output logic               armed
);
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    state_t state;
    logic [MAX_LEN-1:0] hist, pat, mask, nhist;
    logic [LEN_W-1:0] fill, plen, nfill;
    logic ovl, sample, match, bad;
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(plen);
        nhist = {hist[MAX_LEN-2:0], dataIn};
        nfill = fill == plen ? fill : fill + 1'b1;
        sample = enable && state != IDLE && !cfgLoad;
        match = sample && nfill == plen && ((nhist ^ pat) & mask) == '0;
        bad = patLen == '0 || patLen > LEN_W'(MAX_LEN);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            hist <= '0;
            fill <= '0;
            pat <= '0;
            plen <= '0;
            ovl <= 1'b0;
            detected <= 1'b0;
            matchCount <= '0;
            cfgErr <= 1'b0;
        end else begin
            detected <= 1'b0;
            if (clrCount) matchCount <= '0;
            else if (match && matchCount != '1) matchCount <= matchCount + 1'b1;
            if (cfgLoad) begin
                pat <= pattern;
                plen <= patLen;
                ovl <= overlap;
                hist <= '0;
                fill <= '0;
                cfgErr <= bad;
                state <= bad ? IDLE : FILL;
            end else if (sample) begin
                // non-overlap restarts the fill so older bits cannot complete another match
                hist <= nhist;
                detected <= match;
                fill <= (match && !ovl) ? '0 : nfill;
                state <= ((match && !ovl) || nfill != plen) ? FILL : RUN;
            end
        end
    end
    assign armed = state != IDLE;
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised successor to the fixed-pattern serial sequence detector. It watches a 1-bit serial stream (dataIn) against a runtime-programmable pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping matching. It pulses detected on each match and keeps a saturating match counter. It sits on serial input paths ahead of framing/sync logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of patLen port
CNT_W, 8, width of matchCount

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  dataIn sampled only on edges where enable=1
dataIn  input  1  serial data bit
cfgLoad  input  1  one-cycle strobe: latch pattern/patLen/overlap
pattern  input  MAX_LEN  pattern bits; pattern[patLen-1] = first bit received, pattern[0] = last
patLen  input  LEN_W  active pattern length, legal 1..MAX_LEN
overlap  input  1  1 = overlapping matches, 0 = restart history after a match
clrCount  input  1  synchronous clear of matchCount
detected  output  1  registered one-cycle match pulse
matchCount  output  CNT_W  saturating number of matches
cfgErr  output  1  sticky: last cfgLoad had illegal patLen
armed  output  1  1 when a valid config is held (state != IDLE)

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, detected=0, matchCount=0, cfgErr=0, armed=0, history and fill count cleared, latched config cleared. Reset wins over every other input.
- Config: on cfgLoad=1, pattern/patLen/overlap are latched into shadow registers. These inputs are ignored at all other times.
  - If patLen is 0 or >MAX_LEN: cfgErr=1, state=IDLE.
  - Otherwise: cfgErr=0, state=FILL, history and fill count cleared.
  - cfgLoad has priority over a same-cycle data sample. That bit is discarded.
- States:
  - IDLE: no sampling, detected=0.
  - FILL: fill count < latched patLen.
  - RUN: fill count == patLen.
  - FILL->RUN when a sample brings fill count to patLen. A match is possible on that same sample.
- Sampling: on an edge with enable=1 in FILL/RUN, history <= {history[MAX_LEN-2:0], dataIn}. Fill count increments and saturates at patLen.
- Match: evaluated on the new history value. It requires fill count (post-update) == patLen and history[patLen-1:0] == pattern[patLen-1:0].
  - detected is set to 1 on that same edge, so it is visible the cycle after the final bit is sampled (latency 1 clk).
  - detected returns to 0 on the next edge. It is never held more than 1 cycle.
  - With enable=0, detected=0 and history holds.
- Overlap=1: history is kept after a match. Subsequent matches may share bits.
- Overlap=0: after a match, fill count is cleared to 0 (state -> FILL). History bits before the match can never contribute again.
- matchCount: increments by 1 on each detected pulse and saturates at 2^CNT_W-1.
  - clrCount=1 clears it to 0. If clrCount coincides with a match, clear wins and the result is 0.
  - cfgLoad does not clear matchCount.
- patLen=1: every sampled bit equal to pattern[0] produces a pulse in both modes.
- Reset mid-pattern: all partial history is lost. A new cfgLoad is required before detection resumes.

Test Plan:
- Reset, no cfgLoad, toggle dataIn with enable=1 for 20 cycles -> armed=0, detected=0, matchCount=0.
- cfgLoad pattern=8'b00001011, patLen=4, overlap=1; stream 0,1,0,1,1,0,1,0,0,1,1,0,0,1,1,0,0,1,1,1,0,1,1 -> exactly 2 detected pulses, each the cycle after the 5th and 23rd bits are sampled; matchCount=2.
- Same pattern, stream 1,0,1,1,0,1,1: overlap=1 -> 2 pulses, matchCount=2; overlap=0 -> 1 pulse, matchCount=1.
- cfgLoad with patLen=0, then patLen=9 -> cfgErr=1, armed=0, no pulses; then legal patLen=3 -> cfgErr=0, armed=1.
- patLen=1, pattern[0]=1, stream 1,1,0,1 with enable low on the 2nd bit -> 2 pulses; no pulse during the enable=0 cycle.
- CNT_W=2 build: feed 5 matches -> matchCount saturates at 3. Assert clrCount together with a 6th match -> matchCount=0. Assert rst_n=0 mid-pattern -> all outputs return to reset values.
